// File: rtl/datapath_sequencer.sv
// -----------------------------------------------------------------------------
// datapath_sequencer
//
// Multi-cycle controller for the register-file/ALU datapath. One decoded
// operation is accepted per start/done handshake and executed as a fixed
// sequence of load-A, load-B, execute and write-back cycles.
//
// Ports:
//   clk          in   1  sole clock, rising edge
//   reset        in   1  synchronous reset, active-high
//   start        in   1  operation request, sampled only in IDLE
//   op           in   3  000 MOVI, 001 MOV, 010 ADD, 011 CMP, 100 AND,
//                        101 MVN, 110/111 illegal
//   rd, rn, rm   in   3  destination / first source / second source
//   sh           in   2  shift applied to the Rm operand
//   imm          in  16  immediate for MOVI
//   busy         out  1  high in every non-IDLE state
//   done         out  1  one-cycle pulse in DONE
//   err          out  1  pulses with done for an illegal op
//   readnum, writenum, write, loada, loadb, loadc, asel, bsel, vsel,
//   loads, shift, ALUop, datapath_in   datapath control outputs
//
// All outputs are registered. They are decoded from the next state and the
// next latched fields, so in every cycle they equal a Moore decode of the
// current state without a combinational path to the outputs.
// -----------------------------------------------------------------------------
module datapath_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [2:0]  rd,
    input  logic [2:0]  rn,
    input  logic [2:0]  rm,
    input  logic [1:0]  sh,
    input  logic [15:0] imm,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        asel,
    output logic        bsel,
    output logic        vsel,
    output logic        loads,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] datapath_in
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WIMM  = 3'd1;
    localparam logic [2:0] ST_LOADA = 3'd2;
    localparam logic [2:0] ST_LOADB = 3'd3;
    localparam logic [2:0] ST_EXEC  = 3'd4;
    localparam logic [2:0] ST_WRITE = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    localparam logic [2:0] OP_MOVI = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_CMP  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVN  = 3'b101;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    logic [2:0] state_r;
    logic [2:0] op_r;
    logic [2:0] rd_r;
    logic [2:0] rn_r;
    logic [2:0] rm_r;
    logic [1:0] sh_r;

    logic        accept_s;
    logic [2:0]  state_nxt_s;
    logic [2:0]  op_nxt_s;
    logic [2:0]  rd_nxt_s;
    logic [2:0]  rn_nxt_s;
    logic [2:0]  rm_nxt_s;
    logic [1:0]  sh_nxt_s;
    logic [15:0] imm_nxt_s;

    logic        busy_nxt_s;
    logic        done_nxt_s;
    logic        err_nxt_s;
    logic [2:0]  readnum_nxt_s;
    logic [2:0]  writenum_nxt_s;
    logic        write_nxt_s;
    logic        loada_nxt_s;
    logic        loadb_nxt_s;
    logic        loadc_nxt_s;
    logic        asel_nxt_s;
    logic        vsel_nxt_s;
    logic        loads_nxt_s;
    logic [1:0]  shift_nxt_s;
    logic [1:0]  aluop_nxt_s;

    // Next-state and operand-latch logic; fields are captured only on acceptance.
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && start;
        op_nxt_s    = op_r;
        rd_nxt_s    = rd_r;
        rn_nxt_s    = rn_r;
        rm_nxt_s    = rm_r;
        sh_nxt_s    = sh_r;
        imm_nxt_s   = datapath_in;
        state_nxt_s = state_r;
        if (accept_s) begin
            op_nxt_s  = op;
            rd_nxt_s  = rd;
            rn_nxt_s  = rn;
            rm_nxt_s  = rm;
            sh_nxt_s  = sh;
            imm_nxt_s = imm;
        end else begin
            op_nxt_s  = op_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MOVI:                 state_nxt_s = ST_WIMM;
                        OP_MOV, OP_MVN:          state_nxt_s = ST_LOADB;
                        OP_ADD, OP_AND, OP_CMP:  state_nxt_s = ST_LOADA;
                        default:                 state_nxt_s = ST_DONE;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WIMM:  state_nxt_s = ST_DONE;
            ST_LOADA: state_nxt_s = ST_LOADB;
            ST_LOADB: state_nxt_s = ST_EXEC;
            ST_EXEC: begin
                if (op_r == OP_CMP) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_WRITE: state_nxt_s = ST_DONE;
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode of the next state, so the registered outputs track the state.
    always_comb begin
        busy_nxt_s     = (state_nxt_s != ST_IDLE);
        done_nxt_s     = 1'b0;
        err_nxt_s      = 1'b0;
        readnum_nxt_s  = 3'd0;
        writenum_nxt_s = 3'd0;
        write_nxt_s    = 1'b0;
        loada_nxt_s    = 1'b0;
        loadb_nxt_s    = 1'b0;
        loadc_nxt_s    = 1'b0;
        asel_nxt_s     = 1'b0;
        vsel_nxt_s     = 1'b0;
        loads_nxt_s    = 1'b0;
        shift_nxt_s    = 2'b00;
        aluop_nxt_s    = ALU_ADD;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
            end
            ST_WIMM: begin
                vsel_nxt_s     = 1'b1;
                write_nxt_s    = 1'b1;
                writenum_nxt_s = rd_nxt_s;
            end
            ST_LOADA: begin
                readnum_nxt_s = rn_nxt_s;
                loada_nxt_s   = 1'b1;
            end
            ST_LOADB: begin
                readnum_nxt_s = rm_nxt_s;
                loadb_nxt_s   = 1'b1;
            end
            ST_EXEC: begin
                shift_nxt_s = sh_nxt_s;
                case (op_nxt_s)
                    OP_MOV: begin
                        asel_nxt_s  = 1'b1;
                        aluop_nxt_s = ALU_ADD;
                        loadc_nxt_s = 1'b1;
                    end
                    OP_ADD: begin
                        aluop_nxt_s = ALU_ADD;
                        loadc_nxt_s = 1'b1;
                    end
                    OP_AND: begin
                        aluop_nxt_s = ALU_AND;
                        loadc_nxt_s = 1'b1;
                    end
                    OP_MVN: begin
                        aluop_nxt_s = ALU_NOTB;
                        loadc_nxt_s = 1'b1;
                    end
                    OP_CMP: begin
                        aluop_nxt_s = ALU_SUB;
                        loads_nxt_s = 1'b1;
                    end
                    default: begin
                        aluop_nxt_s = ALU_ADD;
                    end
                endcase
            end
            ST_WRITE: begin
                write_nxt_s    = 1'b1;
                writenum_nxt_s = rd_nxt_s;
            end
            ST_DONE: begin
                done_nxt_s = 1'b1;
                // Ops 110/111 are the only ones above MVN.
                err_nxt_s  = (op_nxt_s > OP_MVN);
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // State, latched fields and registered outputs; reset abandons any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            op_r        <= 3'd0;
            rd_r        <= 3'd0;
            rn_r        <= 3'd0;
            rm_r        <= 3'd0;
            sh_r        <= 2'd0;
            datapath_in <= 16'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            readnum     <= 3'd0;
            writenum    <= 3'd0;
            write       <= 1'b0;
            loada       <= 1'b0;
            loadb       <= 1'b0;
            loadc       <= 1'b0;
            asel        <= 1'b0;
            bsel        <= 1'b0;
            vsel        <= 1'b0;
            loads       <= 1'b0;
            shift       <= 2'd0;
            ALUop       <= 2'd0;
        end else begin
            state_r     <= state_nxt_s;
            op_r        <= op_nxt_s;
            rd_r        <= rd_nxt_s;
            rn_r        <= rn_nxt_s;
            rm_r        <= rm_nxt_s;
            sh_r        <= sh_nxt_s;
            datapath_in <= imm_nxt_s;
            busy        <= busy_nxt_s;
            done        <= done_nxt_s;
            err         <= err_nxt_s;
            readnum     <= readnum_nxt_s;
            writenum    <= writenum_nxt_s;
            write       <= write_nxt_s;
            loada       <= loada_nxt_s;
            loadb       <= loadb_nxt_s;
            loadc       <= loadc_nxt_s;
            asel        <= asel_nxt_s;
            bsel        <= 1'b0;
            vsel        <= vsel_nxt_s;
            loads       <= loads_nxt_s;
            shift       <= shift_nxt_s;
            ALUop       <= aluop_nxt_s;
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// -----------------------------------------------------------------------------
// tb_datapath_sequencer
//
// Directed and randomized bench for datapath_sequencer. Expected outputs come
// from a per-operation step list (the state sequence each op walks through)
// and a table of the control values each step must present, plus an
// independent accept-to-done latency table.
// -----------------------------------------------------------------------------
module tb_datapath_sequencer;

    localparam int K_IDLE  = 0;
    localparam int K_WIMM  = 1;
    localparam int K_LOADA = 2;
    localparam int K_LOADB = 3;
    localparam int K_EXEC  = 4;
    localparam int K_WRITE = 5;
    localparam int K_DONE  = 6;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op_v;
    logic [2:0]  rd_v;
    logic [2:0]  rn_v;
    logic [2:0]  rm_v;
    logic [1:0]  sh_v;
    logic [15:0] imm_v;
    logic        busy, done, err;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, asel, bsel, vsel, loads;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;

    int n_cmp;
    int n_fail;
    logic [15:0] model_imm;

    datapath_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op_v), .rd(rd_v),
        .rn(rn_v), .rm(rm_v), .sh(sh_v), .imm(imm_v), .busy(busy),
        .done(done), .err(err), .readnum(readnum), .writenum(writenum),
        .write(write), .loada(loada), .loadb(loadb), .loadc(loadc),
        .asel(asel), .bsel(bsel), .vsel(vsel), .loads(loads),
        .shift(shift), .ALUop(ALUop), .datapath_in(datapath_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [36:0] obs();
        return {busy, done, err, write, loada, loadb, loadc, asel, bsel, vsel,
                loads, readnum, writenum, shift, ALUop, datapath_in};
    endfunction

    // Control values required in a given step of a given operation.
    function automatic logic [36:0] exp_vec(int k, logic [2:0] o, logic [2:0] d,
                                            logic [2:0] n, logic [2:0] m,
                                            logic [1:0] s, logic [15:0] im);
        logic e_busy, e_done, e_err, e_write, e_la, e_lb, e_lc, e_asel, e_vsel, e_ls;
        logic [2:0] e_rn, e_wn;
        logic [1:0] e_sh, e_alu;
        e_busy  = (k != K_IDLE);
        e_done  = (k == K_DONE);
        e_err   = (k == K_DONE) && (o == 3'd6 || o == 3'd7);
        e_write = (k == K_WIMM) || (k == K_WRITE);
        e_la    = (k == K_LOADA);
        e_lb    = (k == K_LOADB);
        e_lc    = (k == K_EXEC) && (o != 3'd3);
        e_asel  = (k == K_EXEC) && (o == 3'd1);
        e_vsel  = (k == K_WIMM);
        e_ls    = (k == K_EXEC) && (o == 3'd3);
        e_rn    = (k == K_LOADA) ? n : ((k == K_LOADB) ? m : 3'd0);
        e_wn    = e_write ? d : 3'd0;
        e_sh    = (k == K_EXEC) ? s : 2'd0;
        e_alu   = 2'd0;
        if (k == K_EXEC) begin
            if (o == 3'd3) e_alu = 2'b01;
            else if (o == 3'd4) e_alu = 2'b10;
            else if (o == 3'd5) e_alu = 2'b11;
            else e_alu = 2'b00;
        end
        return {e_busy, e_done, e_err, e_write, e_la, e_lb, e_lc, e_asel, 1'b0,
                e_vsel, e_ls, e_rn, e_wn, e_sh, e_alu, im};
    endfunction

    task automatic check(input string tag, input logic [36:0] got, input logic [36:0] expv);
        n_cmp++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, expv);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int expv);
        n_cmp++;
        assert (got == expv) else begin
            n_fail++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, expv);
        end
    endtask

    task automatic scramble();
        op_v  = 3'($urandom);
        rd_v  = 3'($urandom);
        rn_v  = 3'($urandom);
        rm_v  = 3'($urandom);
        sh_v  = 2'($urandom);
        imm_v = 16'($urandom);
    endtask

    // Issue one op (entered just after a rising edge, DUT idle) and check every
    // cycle through the trailing IDLE cycle. With hold set, start and the
    // fields stay asserted so a follow-on op is requested immediately.
    task automatic run_op(input logic [2:0] o, input logic [2:0] d, input logic [2:0] n,
                          input logic [2:0] m, input logic [1:0] s, input logic [15:0] im,
                          input bit hold);
        int steps[$];
        int lat_tab[8] = '{2, 4, 5, 4, 5, 4, 1, 1};
        int done_at;
        start = 1'b1; op_v = o; rd_v = d; rn_v = n; rm_v = m; sh_v = s; imm_v = im;
        @(posedge clk); #1;
        if (!hold) begin
            start = 1'b0;
            scramble();
        end
        model_imm = im;
        case (o)
            3'd0:       steps = '{K_WIMM, K_DONE};
            3'd1, 3'd5: steps = '{K_LOADB, K_EXEC, K_WRITE, K_DONE};
            3'd2, 3'd4: steps = '{K_LOADA, K_LOADB, K_EXEC, K_WRITE, K_DONE};
            3'd3:       steps = '{K_LOADA, K_LOADB, K_EXEC, K_DONE};
            default:    steps = '{K_DONE};
        endcase
        done_at = 0;
        for (int i = 0; i < steps.size(); i++) begin
            check($sformatf("op%0d_step%0d", o, i + 1), obs(),
                  exp_vec(steps[i], o, d, n, m, s, im));
            if (done === 1'b1 && done_at == 0) done_at = i + 1;
            @(posedge clk); #1;
        end
        check_int($sformatf("op%0d_latency", o), done_at, lat_tab[o]);
        check($sformatf("op%0d_idle_after", o), obs(),
              exp_vec(K_IDLE, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, model_imm));
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        model_imm = 16'd0;
        reset = 1'b1;
        start = 1'b0;
        op_v = 3'd0; rd_v = 3'd0; rn_v = 3'd0; rm_v = 3'd0; sh_v = 2'd0; imm_v = 16'd0;

        // Reset for two cycles, then three quiet idle cycles.
        repeat (2) @(posedge clk);
        #1;
        check("reset", obs(), 37'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("idle%0d", i), obs(), 37'd0);
        end

        // MOVI R0=7, MOVI R1=2.
        run_op(3'd0, 3'd0, 3'd5, 3'd6, 2'd3, 16'd7, 1'b0);
        run_op(3'd0, 3'd1, 3'd2, 3'd3, 2'd1, 16'd2, 1'b0);
        // ADD R2,R1,R0 with LSL1.
        run_op(3'd2, 3'd2, 3'd1, 3'd0, 2'b01, 16'h1234, 1'b0);
        // CMP R0,R0.
        run_op(3'd3, 3'd4, 3'd0, 3'd0, 2'b00, 16'h00ff, 1'b0);
        // Illegal ops.
        run_op(3'd7, 3'd3, 3'd2, 3'd1, 2'b10, 16'hbeef, 1'b0);
        run_op(3'd6, 3'd1, 3'd1, 3'd1, 2'b11, 16'h0001, 1'b0);
        // AND and MVN.
        run_op(3'd4, 3'd5, 3'd6, 3'd7, 2'b10, 16'h8001, 1'b0);
        run_op(3'd5, 3'd7, 3'd3, 3'd2, 2'b11, 16'h4242, 1'b0);

        // start held through a MOV: the next MOV starts after exactly one IDLE cycle.
        run_op(3'd1, 3'd6, 3'd2, 3'd4, 2'b01, 16'h0a0a, 1'b1);
        run_op(3'd1, 3'd6, 3'd2, 3'd4, 2'b01, 16'h0a0a, 1'b0);

        // Reset during EXEC of ADD R3: no write-back, no done, IDLE next cycle.
        start = 1'b1; op_v = 3'd2; rd_v = 3'd3; rn_v = 3'd1; rm_v = 3'd2; sh_v = 2'd0;
        imm_v = 16'h5a5a;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        check("rst_mid_loada", obs(), exp_vec(K_LOADA, 3'd2, 3'd3, 3'd1, 3'd2, 2'd0, 16'h5a5a));
        @(posedge clk); #1;
        check("rst_mid_loadb", obs(), exp_vec(K_LOADB, 3'd2, 3'd3, 3'd1, 3'd2, 2'd0, 16'h5a5a));
        @(posedge clk); #1;
        check("rst_mid_exec", obs(), exp_vec(K_EXEC, 3'd2, 3'd3, 3'd1, 3'd2, 2'd0, 16'h5a5a));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_imm = 16'd0;
        check("rst_mid_after", obs(), 37'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("rst_mid_quiet%0d", i), obs(), 37'd0);
        end

        // Randomized operations with random idle gaps.
        for (int t = 0; t < 40; t++) begin
            run_op(3'($urandom_range(7, 0)), 3'($urandom), 3'($urandom), 3'($urandom),
                   2'($urandom), 16'($urandom), 1'b0);
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
                @(posedge clk); #1;
                check($sformatf("gap%0d_%0d", t, g), obs(),
                      exp_vec(K_IDLE, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, model_imm));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multi-cycle controller that drives the Lab 5 `datapath` control inputs to execute one register-level operation per request. It accepts a decoded operation over a start/done handshake and steps through load-A, load-B, execute and write-back cycles. It produces every `datapath` control signal, so a bench or a later instruction decoder issues operations instead of toggling individual loads.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- `clk` in 1: sole clock; all state changes on the rising edge.
- `reset` in 1: synchronous reset, active-high.
- `start` in 1: request an operation; sampled only in IDLE.
- `op` in 3: 000 MOVI, 001 MOV, 010 ADD, 011 CMP, 100 AND, 101 MVN; 110/111 illegal.
- `rd`, `rn`, `rm` in 3 each: destination, first source and second source register numbers.
- `sh` in 2: shift applied to the Rm operand (00 none, 01 LSL1, 10 LSR1, 11 ASR1).
- `imm` in 16: immediate value for MOVI.
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle pulse in the DONE state.
- `err` out 1: one-cycle pulse with `done` for an illegal op.
- Datapath controls:
  - `readnum`, `writenum` out 3 each.
  - `write`, `loada`, `loadb`, `loadc`, `asel`, `bsel`, `vsel`, `loads` out 1 each.
  - `shift`, `ALUop` out 2 each.
  - `datapath_in` out 16.

## Operation
- On an accepting edge (state IDLE and `start`=1), latch `op`, `rd`, `rn`, `rm`, `sh` and `imm` into internal registers. The inputs are don't-care afterwards.
- ALUop encoding: 00 add, 01 subtract, 10 AND, 11 NOT B.
- States: IDLE, WIMM, LOADA, LOADB, EXEC, WRITE, DONE.
- State sequences:
  - MOVI: WIMM, DONE.
  - MOV, MVN: LOADB, EXEC, WRITE, DONE.
  - ADD, AND: LOADA, LOADB, EXEC, WRITE, DONE.
  - CMP: LOADA, LOADB, EXEC, DONE.
  - Illegal: DONE with `err`=1; no write and no loads.
- Outputs are a Moore decode of the state plus the latched fields. Every strobe not listed for a state is 0.
- Per-state outputs:
  - WIMM: `vsel`=1, `write`=1, `writenum`=rd.
  - LOADA: `readnum`=rn, `loada`=1.
  - LOADB: `readnum`=rm, `loadb`=1.
  - EXEC: `shift`=sh, `bsel`=0.
    - MOV: `asel`=1, `ALUop`=00, `loadc`=1.
    - ADD: `asel`=0, `ALUop`=00, `loadc`=1.
    - AND: `asel`=0, `ALUop`=10, `loadc`=1.
    - MVN: `ALUop`=11, `loadc`=1.
    - CMP: `asel`=0, `ALUop`=01, `loads`=1, `loadc`=0.
  - WRITE: `vsel`=0, `write`=1, `writenum`=rd.
- Defaults outside the active states: `readnum`=0, `writenum`=0, `shift`=00, `ALUop`=00.
- `datapath_in` always equals the latched `imm`.
- DONE always returns to IDLE on the next edge.
- `start` in any non-IDLE state, including DONE, is ignored; it is not queued.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err` and all strobes 0; `readnum`, `writenum`, `shift` and `ALUop` 0; latched `imm` and `datapath_in` 0.
- Reset asserted mid-operation returns to IDLE on that edge. Any write-back not yet performed is abandoned, and `done` is not pulsed.
- Latency is counted from the accepting edge to the cycle in which `done`=1:
  - MOVI: 2
  - MOV, MVN, CMP: 4
  - ADD, AND: 5
  - Illegal: 1
- Minimum spacing between operations: at least one IDLE cycle between DONE and the next acceptance.
- Register contents and `datapath_out` are valid on the edge that ends the WRITE or WIMM cycle. `status` is valid on the edge that ends CMP's EXEC cycle. Both are stable by the DONE cycle.
- `busy` rises in the cycle after the accepting edge and falls in the cycle after DONE.

## Test plan
- Reset then idle: hold `reset` for 2 cycles, then `start`=0 for 3 cycles -> all outputs stay 0 and `busy`=0.
- MOVI: issue R0=7, then R1=2 -> each gives `write`=1, `vsel`=1, `writenum`=0 and then 1, `datapath_in`=7 and then 2; `done` arrives exactly 2 cycles after each accept.
- ADD with shift: ADD R2,R1,R0 with `sh`=01 -> LOADA `readnum`=1, LOADB `readnum`=0, EXEC `shift`=01, WRITE `writenum`=2; `datapath_out`=16; `done` at cycle 5.
- CMP: CMP R0,R0 -> `loads`=1 only in EXEC, `write` never asserted, `status`=1; `done` at cycle 4.
- Illegal op and ignored start:
  - `op`=111 -> `done` and `err` both pulse at cycle 1, with no strobes.
  - `start` held high through a MOV -> a second operation begins only after one IDLE cycle.
- Reset mid-operation: assert `reset` during EXEC of ADD R3 -> `write` is never asserted for R3, `done` is never pulsed, and the block is in IDLE the next cycle.
